i2c_arbiter: RTL and testbench

Shares a single `i2c_dri` instance among `N_REQ` register-access requesters, e.g. `i2c_reg_cfg` for WM8978 init, a runtime volume/mute controller and a debug port. It arbitrates round-robin and sequences one I2C transaction per grant. It also enforces a done timeout and a minimum idle gap between transactions. It sits between the requesters and `i2c_dri`, clocked by `dri_clk`.

---
 rtl/i2c_arbiter.sv | 166 ++++++++++++++++
 tb/tb_i2c_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sequencing one i2c_dri transaction per grant
module i2c_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1000,
  parameter int GAP_CYC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_data_w,
  input  logic [N_REQ-1:0]   req_rh_wl,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic               ack,
  output logic [7:0]         data_r,
  output logic               i2c_exec,
  output logic [7:0]         i2c_addr,
  output logic [7:0]         i2c_data_w,
  output logic               i2c_rh_wl,
  input  logic               i2c_done,
  input  logic               i2c_ack,
  input  logic [7:0]         i2c_data_r
);

  localparam int LW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WAIT, S_DONE, S_GAP} state_t;

  state_t          state, state_n;
  logic [LW-1:0]   last, last_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic [LW-1:0]   win, cand;
  logic            found;
  logic [N_REQ-1:0] gnt_n, done_n;
  logic            err_n, ack_n, exec_n, rh_wl_n;
  logic [7:0]      data_r_n, addr_n, data_w_n;
  logic            timeout_hit, gap_end;

  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
  assign gap_end     = (gcnt == GW'(GAP_CYC - 1));

  // Round-robin pick: first pending requester after the previous winner
  always_comb begin
    cand  = last;
    win   = last;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == LW'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; i2c_done only matters in WAIT and beats the timeout
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (|req) state_n = S_EXEC;
      S_EXEC: state_n = S_WAIT;
      S_WAIT: if (i2c_done || timeout_hit) state_n = S_DONE;
      S_DONE: state_n = S_GAP;
      S_GAP:  if (gap_end) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and counters
  always_comb begin
    gnt_n    = gnt;
    done_n   = done;
    err_n    = err;
    ack_n    = ack;
    data_r_n = data_r;
    exec_n   = i2c_exec;
    addr_n   = i2c_addr;
    data_w_n = i2c_data_w;
    rh_wl_n  = i2c_rh_wl;
    last_n   = last;
    tcnt_n   = tcnt;
    gcnt_n   = gcnt;
    case (state)
      S_IDLE: begin
        if (|req) begin
          gnt_n    = N_REQ'(1) << win;
          last_n   = win;
          addr_n   = req_addr[{win, 3'b000} +: 8];
          data_w_n = req_data_w[{win, 3'b000} +: 8];
          rh_wl_n  = req_rh_wl[win];
          exec_n   = 1'b1;
        end
      end
      S_EXEC: begin
        exec_n = 1'b0;
        tcnt_n = '0;
      end
      S_WAIT: begin
        tcnt_n = tcnt + 1'b1;
        if (i2c_done) begin
          done_n   = gnt;
          ack_n    = i2c_ack;
          data_r_n = i2c_data_r;
          err_n    = 1'b0;
        end else if (timeout_hit) begin
          done_n   = gnt;
          err_n    = 1'b1;
          ack_n    = 1'b0;
          data_r_n = 8'h00;
        end
      end
      S_DONE: begin
        done_n = '0;
        err_n  = 1'b0;
        ack_n  = 1'b0;
        gnt_n  = '0;
        gcnt_n = '0;
      end
      S_GAP: gcnt_n = gcnt + 1'b1;
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      ack        <= 1'b0;
      data_r     <= 8'h00;
      i2c_exec   <= 1'b0;
      i2c_addr   <= 8'h00;
      i2c_data_w <= 8'h00;
      i2c_rh_wl  <= 1'b0;
      last       <= LW'(N_REQ - 1);
      tcnt       <= '0;
      gcnt       <= '0;
    end else begin
      gnt        <= gnt_n;
      done       <= done_n;
      err        <= err_n;
      ack        <= ack_n;
      data_r     <= data_r_n;
      i2c_exec   <= exec_n;
      i2c_addr   <= addr_n;
      i2c_data_w <= data_w_n;
      i2c_rh_wl  <= rh_wl_n;
      last       <= last_n;
      tcnt       <= tcnt_n;
      gcnt       <= gcnt_n;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

  localparam int N_REQ   = 3;
  localparam int TIMEOUT = 1000;
  localparam int GAP_CYC = 8;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0] req_data_w;
  logic [N_REQ-1:0]   req_rh_wl;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic               ack;
  logic [7:0]         data_r;
  logic               i2c_exec;
  logic [7:0]         i2c_addr;
  logic [7:0]         i2c_data_w;
  logic               i2c_rh_wl;
  logic               i2c_done;
  logic               i2c_ack;
  logic [7:0]         i2c_data_r;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  i2c_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data_w(req_data_w),
    .req_rh_wl(req_rh_wl), .gnt(gnt), .done(done), .err(err), .ack(ack),
    .data_r(data_r), .i2c_exec(i2c_exec), .i2c_addr(i2c_addr),
    .i2c_data_w(i2c_data_w), .i2c_rh_wl(i2c_rh_wl), .i2c_done(i2c_done),
    .i2c_ack(i2c_ack), .i2c_data_r(i2c_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic wait_exec(input string tag);
    int n;
    n = 0;
    while (i2c_exec !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {gnt, done, err, ack, data_r, i2c_exec, i2c_addr, i2c_data_w, i2c_rh_wl}, 32'd0);
  endtask

  initial begin
    int e;
    int prev;
    int n;
    logic [N_REQ-1:0] exp_g;

    rst = 1'b1; req = '0; req_rh_wl = 3'b010;
    req_addr   = {8'h33, 8'h22, 8'h0A};
    req_data_w = {8'h66, 8'h55, 8'h5F};
    i2c_done = 1'b0; i2c_ack = 1'b0; i2c_data_r = 8'h00;
    tick(); tick();
    chk_all_zero("reset_outputs");

    // single write from requester 0
    rst = 1'b0; req = 3'b001;
    tick();
    chk("w_exec", i2c_exec, 1);
    chk("w_gnt", gnt, 3'b001);
    chk("w_addr", i2c_addr, 8'h0A);
    chk("w_data", i2c_data_w, 8'h5F);
    chk("w_rhwl", i2c_rh_wl, 0);
    tick();
    chk("w_exec_1cyc", i2c_exec, 0);
    repeat (119) tick();
    i2c_done = 1'b1; i2c_ack = 1'b0;
    tick();
    chk("w_done", done, 3'b001);
    chk("w_err", err, 0);
    chk("w_ack", ack, 0);
    chk("w_addr_held", i2c_addr, 8'h0A);
    i2c_done = 1'b0; req = '0;
    tick();
    chk("w_done_1cyc", done, 3'b000);
    chk("w_gnt_clr", gnt, 3'b000);

    // read from requester 1
    req = 3'b010;
    wait_exec("r_exec_seen");
    chk("r_gnt", gnt, 3'b010);
    chk("r_rhwl", i2c_rh_wl, 1);
    chk("r_addr", i2c_addr, 8'h22);
    tick(); tick();
    i2c_done = 1'b1; i2c_ack = 1'b1; i2c_data_r = 8'hA5;
    tick();
    chk("r_done", done, 3'b010);
    chk("r_data", data_r, 8'hA5);
    chk("r_ack", ack, 1);
    i2c_done = 1'b0; i2c_data_r = 8'h11; req = '0;
    tick(); tick(); tick();
    chk("r_data_hold", data_r, 8'hA5);
    chk("r_ack_clr", ack, 0);
    chk("r_done_clr", done, 3'b000);

    // round robin from a fresh reset with all requesters pending
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b111; i2c_data_r = 8'h3C; i2c_ack = 1'b0;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      wait_exec("rr_exec_seen");
      e = cyc;
      exp_g = 3'b001 << (k % 3);
      chk($sformatf("rr_gnt_%0d", k), gnt, exp_g);
      if (prev >= 0) chk($sformatf("rr_space_%0d", k), e - prev, GAP_CYC + 5);
      prev = e;
      tick(); tick();
      i2c_done = 1'b1;
      tick();
      i2c_done = 1'b0;
      chk($sformatf("rr_done_%0d", k), done, exp_g);
    end
    req = '0;

    // timeout with no i2c_done; last winner was 2, requester 0 wins
    req = 3'b001;
    wait_exec("to_exec_seen");
    chk("to_gnt", gnt, 3'b001);
    n = 0;
    while (done === 3'b000 && n < 1100) begin
      tick();
      n++;
    end
    chk("to_latency", n, TIMEOUT + 1);
    chk("to_done", done, 3'b001);
    chk("to_err", err, 1);
    chk("to_ack", ack, 0);
    chk("to_data", data_r, 8'h00);
    req = '0;
    tick(); tick();
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("to_gap_ignore", done, 3'b000);
      tick();
    end

    // i2c_done coincides with the final timeout count
    req = 3'b010; i2c_ack = 1'b1; i2c_data_r = 8'h77;
    wait_exec("co_exec_seen");
    chk("co_gnt", gnt, 3'b010);
    repeat (TIMEOUT) tick();
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0; req = '0;
    chk("co_done", done, 3'b010);
    chk("co_err", err, 0);
    chk("co_ack", ack, 1);
    chk("co_data", data_r, 8'h77);

    // reset in the middle of WAIT
    req = 3'b001;
    wait_exec("rs_exec_seen");
    repeat (50) tick();
    chk("rs_addr_pre", i2c_addr, 8'h0A);
    #2 rst = 1'b1;
    #1 chk_all_zero("rs_async_zero");
    tick();
    chk_all_zero("rs_held_zero");
    req = 3'b110;
    rst = 1'b0;
    wait_exec("rs_exec2_seen");
    chk("rs_gnt_after", gnt, 3'b010);
    chk("rs_no_done", done, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
